// File: rtl/bit_serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package bit_serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Bit counter width: clog2(width), never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder built from two half-adder stages and an OR of their carries.
module full_adder_bit
    import bit_serial_adder_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic p;
    logic g_ab;
    logic g_pc;

    assign p    = a_i ^ b_i;
    assign g_ab = a_i & b_i;
    assign s_o  = p ^ c_i;
    assign g_pc = p & c_i;
    assign c_o  = g_ab | g_pc;

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell plus a registered carry, operands consumed LSB first.
// Subtraction (a - b) is built only when BIT_SERIAL_ADDER_SUB_EN is defined.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned     CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] PenCnt  = CntW'((WIDTH > 1) ? WIDTH - 2 : 0);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             cmsb_q, cmsb_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] b_eff;
    logic             c_init;

`ifdef BIT_SERIAL_ADDER_SUB_EN
    assign b_eff  = sub ? ~b : b;
    assign c_init = sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_eff      = b;
    assign c_init     = 1'b0;
`endif

    logic fa_s;
    logic fa_c;

    // Operands are shifted right each RUN cycle, so bit 0 is always the current bit.
    full_adder_bit u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (c_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        c_d     = c_q;
        cmsb_d  = cmsb_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_eff;
                    c_d     = c_init;
                    cmsb_d  = c_init;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d               = a_q >> 1;
                b_d               = b_q >> 1;
                res_d             = res_q >> 1;
                res_d[WIDTH-1]    = fa_s;
                c_d               = fa_c;
                if (WIDTH > 1 && cnt_q == PenCnt) begin
                    cmsb_d = fa_c;
                end
                if (cnt_q == LastCnt) begin
                    // Publish results only on entry to DONE so outputs hold between operations.
                    sum_d   = res_d;
                    cout_d  = fa_c;
                    ovf_d   = cmsb_q ^ fa_c;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cmsb_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            cmsb_q  <= cmsb_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder: WIDTH=8 and WIDTH=1 instances against an arithmetic model.
module tb_bit_serial_adder;

    typedef struct {
        longint sum;
        bit     cout;
        bit     ovf;
        longint acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic       in_valid8, in_ready8, sub8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       in_valid1, in_ready1, sub1, out_valid1, out_ready1, cout1, ovf1;
    logic [0:0] a1, b1, sum1;

    exp_t   q8[$];
    exp_t   q1[$];
    longint last_acc8 = -1;
    longint last_acc1 = -1;

    bit_serial_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .sub       (sub8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .carry_out (cout8),
        .overflow  (ovf8)
    );

    bit_serial_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .sub       (sub1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .carry_out (cout1),
        .overflow  (ovf1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Plain integer arithmetic: wrapped sum, unsigned carry/no-borrow, signed range overflow.
    function automatic exp_t model(input int w, input longint a, input longint b, input bit s,
                                   input longint acc);
        exp_t   e;
        longint m, r, sa, sb, sr;
`ifndef BIT_SERIAL_ADDER_SUB_EN
        s = 1'b0;
`endif
        m  = longint'(1) << w;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        if (s) begin
            r      = a - b;
            e.cout = (a >= b);
            sr     = sa - sb;
        end else begin
            r      = a + b;
            e.cout = (r >= m);
            sr     = sa + sb;
        end
        e.sum = r & (m - 1);
        e.ovf = (sr < -(m / 2)) || (sr >= m / 2);
        e.acc = acc;
        return e;
    endfunction

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit s, input bit push,
                         input bit gap, input bit rnd);
        int     t = 0;
        longint acc;
        while (!in_ready8 && t < 300) begin
            if (rnd) out_ready8 = 1'($urandom);
            @(negedge clk);
            t++;
        end
        if (!in_ready8) begin
            fail_now("w8 in_ready timeout");
            return;
        end
        a8 = a; b8 = b; sub8 = s; in_valid8 = 1'b1;
        acc = longint'(cyc) + 1;
        if (push) q8.push_back(model(8, longint'(a), longint'(b), s, acc));
        if (gap && last_acc8 >= 0) check("w8 throughput", acc - last_acc8, 10);
        last_acc8 = acc;
        @(negedge clk);
        in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
        check("w8 in_ready low in RUN", in_ready8, 0);
    endtask

    task automatic send1(input logic a, input logic b, input bit s, input bit gap);
        int     t = 0;
        longint acc;
        while (!in_ready1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready1) begin
            fail_now("w1 in_ready timeout");
            return;
        end
        a1 = a; b1 = b; sub1 = s; in_valid1 = 1'b1;
        acc = longint'(cyc) + 1;
        q1.push_back(model(1, longint'(a), longint'(b), s, acc));
        if (gap && last_acc1 >= 0) check("w1 throughput", acc - last_acc1, 3);
        last_acc1 = acc;
        @(negedge clk);
        in_valid1 = 1'b0;
        check("w1 in_ready low in RUN", in_ready1, 0);
    endtask

    task automatic wait_idle8();
        int t = 0;
        while (!in_ready8 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready8) fail_now("w8 idle timeout");
    endtask

    // Monitors sample 1 time unit after the falling edge, after the drivers have settled.
    logic       pv8 = 1'b0, pc8, po8;
    logic [7:0] ps8;
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            pv8 = 1'b0;
        end else begin
            if (pv8) begin
                check("w8 out_valid held", out_valid8, 1);
                check("w8 sum held", sum8, ps8);
                check("w8 carry held", cout8, pc8);
                check("w8 overflow held", ovf8, po8);
            end
            if (out_valid8 && !pv8) begin
                if (q8.size() == 0) fail_now("w8 unexpected out_valid");
                else check("w8 latency", longint'(cyc) - q8[0].acc, 8);
            end
            if (out_valid8) check("w8 in_ready low in DONE", in_ready8, 0);
            if (out_valid8 && out_ready8 && q8.size() != 0) begin
                e = q8.pop_front();
                check("w8 sum", sum8, e.sum);
                check("w8 carry_out", cout8, e.cout);
                check("w8 overflow", ovf8, e.ovf);
            end
            pv8 = out_valid8 && !out_ready8;
            ps8 = sum8; pc8 = cout8; po8 = ovf8;
        end
    end

    logic pv1 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            pv1 = 1'b0;
        end else begin
            if (out_valid1 && !pv1) begin
                if (q1.size() == 0) fail_now("w1 unexpected out_valid");
                else check("w1 latency", longint'(cyc) - q1[0].acc, 1);
            end
            if (out_valid1 && out_ready1 && q1.size() != 0) begin
                e = q1.pop_front();
                check("w1 sum", sum1, e.sum);
                check("w1 carry_out", cout1, e.cout);
                check("w1 overflow", ovf1, e.ovf);
            end
            pv1 = out_valid1 && !out_ready1;
        end
    end

    initial begin
        int t;
        rst_n = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; out_ready8 = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0; out_ready1 = 1'b1;
        repeat (3) @(negedge clk);
        check("w8 reset in_ready", in_ready8, 1);
        check("w8 reset out_valid", out_valid8, 0);
        check("w8 reset sum", sum8, 0);
        check("w8 reset carry_out", cout8, 0);
        check("w8 reset overflow", ovf8, 0);
        check("w1 reset in_ready", in_ready1, 1);
        check("w1 reset out_valid", out_valid1, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corners, back to back with out_ready high.
        send8(8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        send8(8'hFF, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
        send8(8'h7F, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
        send8(8'h05, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        send8(8'h80, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++)
            send8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b1, 1'b0);

        // Backpressure: hold DONE for several cycles while the inputs wiggle.
        wait_idle8();
        out_ready8 = 1'b0;
        send8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
        t = 0;
        while (!out_valid8 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid8) fail_now("w8 out_valid timeout");
        repeat (5) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        check("w8 in_ready after accept", in_ready8, 1);
        check("w8 out_valid after accept", out_valid8, 0);

        // Reset mid-run at counter 3; the partial result must vanish.
        send8(8'h40, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_idle8();
        send8(8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("w8 midreset in_ready", in_ready8, 1);
        check("w8 midreset out_valid", out_valid8, 0);
        check("w8 midreset sum", sum8, 0);
        check("w8 midreset carry_out", cout8, 0);
        check("w8 midreset overflow", ovf8, 0);
        send8(8'h12, 8'h34, 1'b0, 1'b1, 1'b0, 1'b0);

        // Random traffic with random consumer stalls.
        for (int i = 0; i < 25; i++)
            send8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b1);
        out_ready8 = 1'b1;

        // WIDTH=1: single-cycle RUN, one result every three cycles.
        send1(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            send1(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);

        t = 0;
        while ((q8.size() != 0 || q1.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (q8.size() != 0) fail_now("w8 results outstanding at end");
        if (q1.size() != 0) fail_now("w1 results outstanding at end");
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
